// File: rtl/prior_bank_stoch_log_pkg.sv
// Shared types for the prior bank: FSM states, output mode and LFSR tap masks.
package prior_bank_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef enum logic {MODE_STOCH = 1'b0, MODE_LOG = 1'b1} mode_t;

    localparam int PW_NARROW = 8;
    localparam int PW_WIDE   = 16;

    // Fibonacci tap masks, bit k set means stage k+1 feeds the XOR.
    localparam logic [15:0] TAPS_PW8  = 16'h00B8;  // 8,6,5,4
    localparam logic [15:0] TAPS_PW16 = 16'hD008;  // 16,15,13,4

    function automatic logic [15:0] lfsr_taps(input int width);
        logic [15:0] mask;
        mask = (width == PW_WIDE) ? TAPS_PW16 : TAPS_PW8;
        return mask;
    endfunction

endpackage

// File: rtl/prior_bank_stoch_log_if.sv
// Configuration and output bundle of the prior bank.
interface prior_bank_stoch_log_if #(
    parameter int NROWS = 4,
    parameter int PW    = 8,
    parameter int CNTW  = 16,
    parameter int ADRW  = $clog2(NROWS)
);
    logic              mode;
    logic              clear;
    logic              load_valid;
    logic              load_ready;
    logic              load_bcast;
    logic [ADRW-1:0]   load_row;
    logic [PW-1:0]     load_data;
    logic              seed_valid;
    logic [PW-1:0]     seed;
    logic              start;
    logic [CNTW-1:0]   n_samples;
    logic              busy;
    logic              done;
    logic              stoch_valid;
    logic [NROWS-1:0]  prior_stoch;
    logic [PW-1:0]     prior_log [NROWS];

    modport master (
        output mode, clear, load_valid, load_bcast, load_row, load_data,
               seed_valid, seed, start, n_samples,
        input  load_ready, busy, done, stoch_valid, prior_stoch, prior_log
    );

    modport slave (
        input  mode, clear, load_valid, load_bcast, load_row, load_data,
               seed_valid, seed, start, n_samples,
        output load_ready, busy, done, stoch_valid, prior_stoch, prior_log
    );
endinterface

// File: rtl/prior_bank_stoch_log_lfsr.sv
// Maximal-length Fibonacci LFSR with seed load, zero-seed guard and step enable.
module prior_lfsr
    import prior_bank_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          en,
    input  logic [PW-1:0] seed,
    output logic [PW-1:0] value
);
    localparam logic [15:0]   TAPS_FULL = lfsr_taps(PW);
    localparam logic [PW-1:0] TAPS      = TAPS_FULL[PW-1:0];
    localparam logic [PW-1:0] ONE       = PW'(1);

    logic fb;

    assign fb = ^(value & TAPS);

    // Seed load wins over stepping; an all-zero seed would lock up, so it becomes 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= ONE;
        else if (load)
            value <= (seed == '0) ? ONE : seed;
        else if (en)
            value <= {value[PW-2:0], fb};
    end
endmodule

// File: rtl/prior_bank_stoch_log.sv
// Prior bank with log (parallel) and stochastic (Bernoulli burst) outputs.
// Optional macro PRIOR_ROW_DECORRELATE_EN: row i compares against the LFSR rotated left by i.
module prior_bank_stoch_log
    import prior_bank_pkg::*;
#(
    parameter  int NROWS = 4,
    parameter  int PW    = 8,
    parameter  int CNTW  = 16,
    localparam int ADRW  = $clog2(NROWS)
) (
    input  logic clk,
    input  logic rst,
    prior_bank_stoch_log_if.slave bus
);
    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    mode_t            mode_q;
    logic [PW-1:0]    prior_q [NROWS];
    logic [PW-1:0]    prior_d [NROWS];
    logic [PW-1:0]    lfsr_val;
    logic             sample_en;
    logic [NROWS-1:0] sample_bits;
    logic [NROWS-1:0] stoch_q;
    logic             valid_q;
    logic             in_idle;

    assign in_idle = (state_q == IDLE);

    prior_lfsr #(.PW(PW)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (bus.seed_valid && in_idle),
        .en    (sample_en),
        .seed  (bus.seed),
        .value (lfsr_val)
    );

    // Next state and sample strobe; the first sample is taken on the accepting start edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sample_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && mode_t'(bus.mode) == MODE_STOCH) begin
                    if (bus.n_samples == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d   = RUN;
                        cnt_d     = bus.n_samples - CNTW'(1);
                        sample_en = 1'b1;
                    end
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d     = cnt_q - CNTW'(1);
                    sample_en = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Prior write path: clear beats load; out-of-range rows match no entry and are dropped.
    always_comb begin
        for (int i = 0; i < NROWS; i++) prior_d[i] = prior_q[i];
        if (in_idle) begin
            if (bus.clear) begin
                for (int i = 0; i < NROWS; i++) prior_d[i] = '0;
            end else if (bus.load_valid) begin
                for (int i = 0; i < NROWS; i++)
                    if (bus.load_bcast || ADRW'(i) == bus.load_row)
                        prior_d[i] = bus.load_data;
            end
        end
    end

    // Bernoulli compare against the next prior value so a load taken with start is used at once.
    always_comb begin
        sample_bits = '0;
        for (int i = 0; i < NROWS; i++) begin
`ifdef PRIOR_ROW_DECORRELATE_EN
            logic [2*PW-1:0] dbl;
            dbl = {lfsr_val, lfsr_val} << (i % PW);
            sample_bits[i] = (dbl[2*PW-1:PW] <= prior_d[i]);
`else
            sample_bits[i] = (lfsr_val <= prior_d[i]);
`endif
        end
    end

    // State, counter, latched mode and prior storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_STOCH;
            for (int i = 0; i < NROWS; i++) prior_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (in_idle) mode_q <= mode_t'(bus.mode);
            for (int i = 0; i < NROWS; i++) prior_q[i] <= prior_d[i];
        end
    end

    // Registered stochastic outputs, forced to zero whenever no sample is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            stoch_q <= '0;
        end else begin
            valid_q <= sample_en;
            stoch_q <= sample_en ? sample_bits : '0;
        end
    end

    assign bus.load_ready  = in_idle;
    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.stoch_valid = valid_q;
    assign bus.prior_stoch = stoch_q;

    // Parallel prior view, only while log mode is latched.
    always_comb begin
        for (int i = 0; i < NROWS; i++)
            bus.prior_log[i] = (mode_q == MODE_LOG) ? prior_q[i] : '0;
    end
endmodule

// File: tb/tb_prior_bank_stoch_log.sv
// Scoreboard bench for prior_bank_stoch_log (NROWS=4, PW=8).
module tb_prior_bank_stoch_log;
    localparam int NROWS = 4;
    localparam int PW    = 8;
    localparam int CNTW  = 16;

    typedef struct {
        int         n;
        int         ones [4];
        logic [3:0] mask;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prior_bank_stoch_log_if #(.NROWS(NROWS), .PW(PW), .CNTW(CNTW)) bus ();

    prior_bank_stoch_log #(.NROWS(NROWS), .PW(PW), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];

    int acc_n, acc_busy;
    int acc_ones [4];
    logic prev_valid;
    logic [15:0] hist0, hist1, last_hist0, last_hist1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic clr_acc();
        acc_n = 0; acc_busy = 0; prev_valid = 1'b0; hist0 = '0; hist1 = '0;
        for (int i = 0; i < 4; i++) acc_ones[i] = 0;
    endtask

    // Monitor: accumulates each burst and compares against the queued expectation at done.
    always @(negedge clk) begin
        if (rst) begin
            clr_acc();
        end else begin
            if (bus.stoch_valid) begin
                acc_n++;
                for (int i = 0; i < 4; i++) acc_ones[i] += int'(bus.prior_stoch[i]);
                hist0 = {hist0[14:0], bus.prior_stoch[0]};
                hist1 = {hist1[14:0], bus.prior_stoch[1]};
            end else begin
                chk("stoch_zero_when_invalid", 32'(bus.prior_stoch), 32'h0);
            end
            if (bus.busy) acc_busy++;
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no burst at %0t", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("valid_count", acc_n, e.n);
                    chk("busy_count", acc_busy, e.n);
                    chk("done_after_last_valid", 32'(prev_valid), 32'(e.n > 0));
                    for (int i = 0; i < 4; i++)
                        if (e.mask[i]) chk($sformatf("ones_row%0d", i), acc_ones[i], e.ones[i]);
                end
                last_hist0 = hist0;
                last_hist1 = hist1;
                clr_acc();
            end
            prev_valid = bus.stoch_valid;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load_one(input int row, input int data);
        bus.load_bcast = 1'b0; bus.load_row = 2'(row); bus.load_data = 8'(data);
        bus.load_valid = 1'b1; tick(); bus.load_valid = 1'b0;
    endtask

    task automatic load_all4(input int d0, input int d1, input int d2, input int d3);
        load_one(0, d0); load_one(1, d1); load_one(2, d2); load_one(3, d3);
    endtask

    task automatic do_seed(input int s);
        bus.seed = 8'(s); bus.seed_valid = 1'b1; tick(); bus.seed_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        chk("done_within_budget", 32'(seen), 32'h1);
        tick();
    endtask

    task automatic run_burst(input int n, input int o0, input int o1, input int o2,
                             input int o3, input logic [3:0] mask);
        exp_t e;
        e.n = n; e.ones[0] = o0; e.ones[1] = o1; e.ones[2] = o2; e.ones[3] = o3; e.mask = mask;
        exp_q.push_back(e);
        bus.mode = 1'b0; bus.n_samples = 16'(n); bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(n + 8);
    endtask

    task automatic chk_log(input int d0, input int d1, input int d2, input int d3);
        chk("prior_log0", 32'(bus.prior_log[0]), 32'(d0));
        chk("prior_log1", 32'(bus.prior_log[1]), 32'(d1));
        chk("prior_log2", 32'(bus.prior_log[2]), 32'(d2));
        chk("prior_log3", 32'(bus.prior_log[3]), 32'(d3));
    endtask

    initial begin
        bus.mode = 1'b0; bus.clear = 1'b0; bus.load_valid = 1'b0; bus.load_bcast = 1'b0;
        bus.load_row = '0; bus.load_data = '0; bus.seed_valid = 1'b0; bus.seed = '0;
        bus.start = 1'b0; bus.n_samples = '0;
        clr_acc();
        last_hist0 = '0; last_hist1 = '0;

        // Reset values
        #12;
        chk("rst_load_ready", 32'(bus.load_ready), 32'h1);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_stoch_valid", 32'(bus.stoch_valid), 32'h0);
        chk("rst_prior_stoch", 32'(bus.prior_stoch), 32'h0);
        chk_log(0, 0, 0, 0);
        @(posedge clk); #1; rst = 1'b0;
        tick();

        // Full-period burst: ones counts equal the priors exactly
        load_all4(0, 255, 128, 1);
        run_burst(255, 0, 255, 128, 1, 4'hF);

        // Broadcast then per-row load, shown in log mode
        bus.load_bcast = 1'b1; bus.load_data = 8'h40; bus.load_valid = 1'b1; tick();
        bus.load_valid = 1'b0; bus.load_bcast = 1'b0;
        load_one(2, 8'h10);
        bus.mode = 1'b1; tick();
        chk_log(8'h40, 8'h40, 8'h10, 8'h40);
        chk("log_prior_stoch", 32'(bus.prior_stoch), 32'h0);
        bus.n_samples = 16'd5; bus.start = 1'b1; tick(); bus.start = 1'b0;
        chk("start_in_log_ignored", 32'(bus.busy), 32'h0);
        bus.clear = 1'b1; bus.load_row = 2'd1; bus.load_data = 8'h77; bus.load_valid = 1'b1;
        tick();
        bus.clear = 1'b0; bus.load_valid = 1'b0;
        chk_log(0, 0, 0, 0);
        bus.mode = 1'b0; tick();
        chk("stoch_mode_log_zero", 32'(bus.prior_log[1]), 32'h0);

        // Load held during RUN is refused, then taken in the first IDLE cycle
        begin
            exp_t e;
            bit seen;
            do_seed(1);
            load_all4(0, 255, 0, 255);
            e.n = 5; e.ones[0] = 0; e.ones[1] = 5; e.ones[2] = 0; e.ones[3] = 5; e.mask = 4'hF;
            exp_q.push_back(e);
            bus.n_samples = 16'd5; bus.start = 1'b1; tick(); bus.start = 1'b0;
            bus.load_row = 2'd0; bus.load_data = 8'h55; bus.load_bcast = 1'b0; bus.load_valid = 1'b1;
            seen = 0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                if (bus.done) seen = 1;
                else if (bus.busy) chk("ready_low_in_run", 32'(bus.load_ready), 32'h0);
            end
            chk("run_done_within_budget", 32'(seen), 32'h1);
            tick();
            chk("ready_after_done", 32'(bus.load_ready), 32'h1);
            tick();
            bus.load_valid = 1'b0;
            bus.mode = 1'b1; tick();
            chk_log(8'h55, 255, 0, 255);
            bus.mode = 1'b0; tick();
        end

        // Zero-length burst
        run_burst(0, 0, 0, 0, 0, 4'hF);

        // Reset in the middle of a burst, then a fresh burst from LFSR=1
        bus.n_samples = 16'd100; bus.start = 1'b1; tick(); bus.start = 1'b0;
        repeat (9) tick();
        rst = 1'b1; #1;
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        chk("midrst_stoch_valid", 32'(bus.stoch_valid), 32'h0);
        chk("midrst_prior_stoch", 32'(bus.prior_stoch), 32'h0);
        chk("midrst_done", 32'(bus.done), 32'h0);
        chk("midrst_load_ready", 32'(bus.load_ready), 32'h1);
        tick(); rst = 1'b0; tick();
        load_all4(1, 255, 0, 0);
        run_burst(3, 1, 3, 0, 0, 4'hF);

        // Zero seed is replaced by 1
        do_seed(0);
        load_all4(1, 255, 255, 255);
        run_burst(4, 1, 4, 4, 4, 4'hF);

        // Two rows with equal priors sharing the LFSR
        do_seed(1);
        load_all4(128, 128, 0, 255);
        run_burst(16, 0, 0, 0, 16, 4'b1100);
`ifdef PRIOR_ROW_DECORRELATE_EN
        chk("rows_decorrelated", 32'(last_hist0 != last_hist1), 32'h1);
`else
        chk("rows_identical", 32'(last_hist0 == last_hist1), 32'h1);
`endif

        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/prior_bank_stoch_log.md
Name: prior_bank_stoch_log

Overview:
- Parametrised successor to the left-side priors decoder. Holds NROWS prior words of PW bits, loaded through a valid/ready handshake, with per-row or broadcast writes.
- Two output modes:
  - Log mode: the stored priors are presented in parallel.
  - Stochastic mode: a controller runs a bounded burst of stochastic bitstreams, one Bernoulli bit per row per cycle, from an internal seeded LFSR.
- Sits between the configuration interface and the left edge of the likelihood array, feeding the row inference logic.

Parameters:
- NROWS, 4, number of prior rows (≥2).
- PW, 8, prior and LFSR width; supported values are 8 and 16.
- CNTW, 16, width of the stream-length counter.
- ADRW, $clog2(NROWS), row address width (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- mode  in  1  0 = stochastic, 1 = log; sampled only in IDLE.
- clear  in  1  zero all priors; honoured only in IDLE.
- load_valid  in  1  prior write request.
- load_ready  out  1  write accepted when load_valid && load_ready.
- load_bcast  in  1  write load_data to all rows.
- load_row  in  ADRW  target row when load_bcast=0.
- load_data  in  PW  prior value.
- seed_valid  in  1  load LFSR seed; honoured only in IDLE.
- seed  in  PW  LFSR seed.
- start  in  1  begin stochastic burst.
- n_samples  in  CNTW  burst length, sampled at start.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at end of burst.
- stoch_valid  out  1  prior_stoch carries a valid sample.
- prior_stoch  out  NROWS  per-row stochastic bits.
- prior_log  out  NROWS x PW  unpacked array of stored priors.

Behaviour:
- Reset (async, rst=1):
  - All priors = 0; LFSR = 1; counter = 0; state = IDLE.
  - Outputs: load_ready=1, busy=0, done=0, stoch_valid=0, prior_stoch=0, prior_log all 0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - load_ready=1.
  - clear has priority over a simultaneous load.
  - A load and a seed in the same cycle are both applied.
  - A seed of 0 is replaced by 1.
  - start with mode=0 latches n_samples and moves to RUN.
  - start with n_samples=0 goes directly to DONE, with no stoch_valid.
  - start with mode=1 is ignored.
- Load accepted in the same cycle as start: the new prior is used for the first sample.
- Load address: load_row ≥ NROWS with load_bcast=0 is accepted and dropped (no write).
- RUN:
  - load_ready=0; clear, seed_valid and mode are ignored.
  - The LFSR advances every cycle.
  - Registered output: prior_stoch[i] = (lfsr <= prior[i]), so the probability is prior/(2^PW-1). Prior 0 never fires; prior all-ones always fires.
  - stoch_valid is high exactly n_samples cycles, starting the cycle after start is accepted.
  - After the final sample cycle, the state moves to DONE.
- DONE:
  - done=1 for one cycle; stoch_valid=0 and prior_stoch=0.
  - The state then returns to IDLE.
  - The LFSR holds its state, so the next burst continues the sequence unless it is reseeded.
- Log mode (mode latched 1 in IDLE): prior_log = stored priors, combinational from registers; prior_stoch=0.
- Stochastic mode: prior_log is all 0.
- LFSR:
  - Fibonacci, maximal length; taps from the package.
  - Width 8 uses taps 8,6,5,4; width 16 uses taps 16,15,13,4.
  - The period is 2^PW-1, never reaching 0.
- Reset asserted mid-RUN: immediate return to reset values; no done pulse.

Optional Feature:
- Macro PRIOR_ROW_DECORRELATE_EN.
  - Defined: row i compares against the LFSR value rotated left by i bits, which decorrelates rows that share one LFSR.
  - Undefined: all rows compare against the same LFSR value.
- The probability per row is identical either way.

Decomposition:
- Package prior_bank_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the mode typedef;
  - the function lfsr_taps(PW) returning the tap mask;
  - the localparams for the supported widths.
- One sub-module, prior_lfsr: a PW-bit LFSR with load, zero-seed guard and enable.

Test Plan:
- PW=8, seed=1, priors {0,255,128,1}, start with n_samples=255 -> stoch_valid high for 255 cycles; ones counts are exactly {0,255,128,1}; done pulses once, on the cycle after the last valid.
- Broadcast load of 0x40 then a per-row load of row2=0x10, mode=1 -> prior_log={0x40,0x40,0x10,0x40}; prior_stoch=0.
- load_valid during RUN -> load_ready=0 and priors unchanged; the same load is accepted in the first IDLE cycle after done.
- start with n_samples=0 -> done on the next cycle; no stoch_valid; busy never high.
- rst asserted at sample 10 of 100 -> all outputs 0 immediately; state IDLE; a subsequent burst without reseeding starts from LFSR=1.
- seed=0 loaded, then prior=255 and n_samples=4 -> 4 ones, confirming the zero-seed guard; with PRIOR_ROW_DECORRELATE_EN, rows 0 and 1 loaded with 128 produce different bit sequences.
